dma_dispatcher: RTL and testbench
=================================

# dma_dispatcher

Descriptor dispatcher for the PIM DMA engine. It buffers descriptors written by the CSR block and issues them one at a time to the read-source FSM and the write-destination FSM. It tracks per-side completion and retires each descriptor only after both sides report done. It also handles the error stop and the software dispatcher reset. It sits between the CSR block and the rd/wr FSM pair, and drives their `descriptor` and `descriptor_fifo_not_empty` inputs.

## Interface
Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `DEPTH`, default 16: descriptor FIFO entries; power of 2, ≥2.
- `CNT_W`, default 32: width of the completed-descriptor counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `desc_in` in `dma_pkg::t_dma_descriptor`: descriptor from CSR.
- `desc_wr_en` in 1: push `desc_in`.
- `desc_full` out 1: FIFO count == DEPTH.
- `desc_count` out $clog2(DEPTH+1): FIFO occupancy (excludes active descriptor).
- `desc_overflow` out 1: sticky; set when a push is dropped.
- `descriptor` out `dma_pkg::t_dma_descriptor`: active descriptor, registered.
- `rd_desc_valid` out 1: drives the rd FSM `descriptor_fifo_not_empty`.
- `wr_desc_valid` out 1: drives the wr FSM `descriptor_fifo_not_empty`.
- `rd_fsm_done` in 1: rd FSM completion pulse.
- `wr_fsm_done` in 1: wr FSM completion pulse.
- `rd_stopped_on_error` in 1: rd FSM error status.
- `wr_stopped_on_error` in 1: wr FSM error status.
- `reset_dispatcher` in 1: CSR abort/flush pulse.
- `busy` out 1: state != IDLE.
- `error` out 1: state == ERROR.
- `done_count` out CNT_W: descriptors retired; wraps.

## Operation
FIFO behaviour:
- Push accepted when `desc_wr_en` & !full. The full check uses the count at the start of the cycle, so a push while full is dropped even if a pop happens in the same cycle.
- A dropped push sets `desc_overflow`.
- Pops happen only in LOAD.

State machine:
- IDLE: count != 0 → LOAD.
- LOAD: capture the FIFO head into `descriptor`, pop it, → RUN. Set `rd_desc_valid` = `wr_desc_valid` = 1 on that edge.
- RUN, done handling:
  - `rd_fsm_done` clears `rd_desc_valid` on the next edge; `wr_fsm_done` clears `wr_desc_valid` on the next edge.
  - A done pulse on a side already cleared is ignored.
  - When both sides are cleared (done on the same cycle, or the second one arrives), `done_count` += 1. Then go to LOAD if count != 0, else IDLE.
- RUN, error: `rd_stopped_on_error` | `wr_stopped_on_error` → ERROR. Both valids clear on that edge and `done_count` is unchanged. Error takes priority over a same-cycle done.
- ERROR: holds until `reset_dispatcher`. Pushes are still accepted.
- `reset_dispatcher` in any state: on the next edge, flush the FIFO (count = 0), clear both valids and `desc_overflow`, go to IDLE. A push in the same cycle is discarded. `done_count` is preserved.

Output behaviour:
- `descriptor` is stable throughout RUN. It is not cleared on retire and keeps the last value.
- Both valids are registered, so each drops on the edge its done is sampled. This stops the FSM, which is back in its IDLE, from restarting on the same descriptor.

## Timing
Reset values:
- state IDLE
- `rd_desc_valid`, `wr_desc_valid`, `busy`, `error`, `desc_overflow`: 0
- `desc_count`, `done_count`: 0
- `descriptor`: '0
- `desc_full`: 0

Latency:
- Push at cycle N into an empty, idle block: count = 1 at N+1, LOAD at N+2, valids high at N+3.
- Last done sampled at cycle M with the FIFO non-empty: LOAD at M+1, valids high at M+2. With the FIFO empty: IDLE at M+1.
- Error at cycle E: ERROR and `error` = 1 at E+1.
- `reset_dispatcher` at cycle R: IDLE with count 0 at R+1.

Arithmetic and status:
- `done_count` wraps from 2^CNT_W−1 to 0.
- `desc_count` updates on the same edge as the push or pop.
- `busy` = (state != IDLE), combinational from state.

## Test plan
- Single descriptor: push D0 at cycle 0 → valids = 1 at cycle 3 with `descriptor` = D0. Pulse `wr_fsm_done` at 10 and `rd_fsm_done` at 14 → `wr_desc_valid` = 0 at 11, `rd_desc_valid` = 0 at 15, `done_count` = 1 and IDLE at 15.
- Back-to-back: push D0–D3; assert both dones on the same cycle M per descriptor → each next descriptor has valids = 1 at M+2, order D0..D3, `done_count` = 4, final `desc_count` = 0.
- Overflow, DEPTH = 16: push 18 while a descriptor is active → `desc_full` = 1 after 16, `desc_overflow` = 1, `desc_count` = 16, and a push on the full cycle with a concurrent pop is still dropped.
- Error: in RUN, assert `wr_stopped_on_error` together with `rd_fsm_done` → ERROR next cycle, valids = 0, `done_count` unchanged, `error` = 1. Then `reset_dispatcher` → IDLE, `desc_count` = 0, `desc_overflow` = 0.
- Mid-operation abort: `reset_dispatcher` during RUN with 3 queued plus a same-cycle push → IDLE, count 0, valids 0, no further LOAD.
- Counter wrap, CNT_W = 4: retire 17 descriptors → `done_count` = 1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the PIM DMA engine.
package dma_pkg;

  // One transfer request as written by the CSR block.
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
  } t_dma_descriptor;

endpackage

// File: rtl/dma_dispatcher_if.sv
// Bundle of CSR-side and rd/wr-FSM-side signals around the descriptor dispatcher.
interface dma_dispatcher_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
);

  dma_pkg::t_dma_descriptor       desc_in;
  logic                           desc_wr_en;
  logic                           desc_full;
  logic [$clog2(DEPTH+1)-1:0]     desc_count;
  logic                           desc_overflow;
  dma_pkg::t_dma_descriptor       descriptor;
  logic                           rd_desc_valid;
  logic                           wr_desc_valid;
  logic                           rd_fsm_done;
  logic                           wr_fsm_done;
  logic                           rd_stopped_on_error;
  logic                           wr_stopped_on_error;
  logic                           reset_dispatcher;
  logic                           busy;
  logic                           error;
  logic [CNT_W-1:0]               done_count;

  // Dispatcher side.
  modport slave (
    input  desc_in, desc_wr_en, rd_fsm_done, wr_fsm_done,
           rd_stopped_on_error, wr_stopped_on_error, reset_dispatcher,
    output desc_full, desc_count, desc_overflow, descriptor,
           rd_desc_valid, wr_desc_valid, busy, error, done_count
  );

  // CSR block / rd-wr FSM side.
  modport master (
    output desc_in, desc_wr_en, rd_fsm_done, wr_fsm_done,
           rd_stopped_on_error, wr_stopped_on_error, reset_dispatcher,
    input  desc_full, desc_count, desc_overflow, descriptor,
           rd_desc_valid, wr_desc_valid, busy, error, done_count
  );

endinterface

// File: rtl/dma_dispatcher.sv
// Descriptor dispatcher: queues CSR descriptors, hands them one at a time to
// the rd/wr FSM pair and retires each only when both sides report done.
module dma_dispatcher #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  dma_dispatcher_if.slave   bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERROR} t_state;

  t_state                   r_state;
  t_state                   w_next;
  dma_pkg::t_dma_descriptor r_mem [DEPTH];
  logic [AW-1:0]            r_wptr;
  logic [AW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;
  logic                     r_overflow;
  logic                     r_rd_valid;
  logic                     r_wr_valid;
  dma_pkg::t_dma_descriptor r_desc;
  logic [CNT_W-1:0]         r_done_count;

  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_flush;
  logic w_err;
  logic w_rd_next;
  logic w_wr_next;
  logic w_load;
  logic w_retire;
  logic w_to_error;

  // Full is judged on the start-of-cycle count, so a pop in the same cycle
  // does not make room for a push.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_flush   = bus.reset_dispatcher;
  assign w_push    = bus.desc_wr_en & ~w_full & ~w_flush;
  assign w_drop    = bus.desc_wr_en & w_full;
  assign w_pop     = w_load;
  assign w_err     = bus.rd_stopped_on_error | bus.wr_stopped_on_error;
  // A done on an already-cleared side leaves it cleared.
  assign w_rd_next = r_rd_valid & ~bus.rd_fsm_done;
  assign w_wr_next = r_wr_valid & ~bus.wr_fsm_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle control strobes; dispatcher flush overrides all.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_retire   = 1'b0;
    w_to_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (w_err) begin
          w_to_error = 1'b1;
          w_next     = S_ERROR;
        end else if (!w_rd_next && !w_wr_next) begin
          w_retire = 1'b1;
          w_next   = (r_count != '0) ? S_LOAD : S_IDLE;
        end
      end
      S_ERROR: begin
        w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_flush) begin
      w_next     = S_IDLE;
      w_load     = 1'b0;
      w_retire   = 1'b0;
      w_to_error = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since pointers/count qualify them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.desc_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky record of any push dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset || w_flush) r_overflow <= 1'b0;
    else if (w_drop)      r_overflow <= 1'b1;
  end

  // Per-side valids: raised on load, each dropped on the edge its done is seen.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
    end else if (w_load) begin
      r_rd_valid <= 1'b1;
      r_wr_valid <= 1'b1;
    end else if (w_to_error) begin
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_rd_valid <= w_rd_next;
      r_wr_valid <= w_wr_next;
    end
  end

  // Active descriptor, held until the next load.
  always_ff @(posedge clk) begin
    if (reset)       r_desc <= '0;
    else if (w_load) r_desc <= r_mem[r_rptr];
  end

  // Retired-descriptor counter; wraps and survives a dispatcher flush.
  always_ff @(posedge clk) begin
    if (reset)         r_done_count <= '0;
    else if (w_retire) r_done_count <= r_done_count + 1'b1;
  end

  assign bus.desc_full     = w_full;
  assign bus.desc_count    = r_count;
  assign bus.desc_overflow = r_overflow;
  assign bus.descriptor    = r_desc;
  assign bus.rd_desc_valid = r_rd_valid;
  assign bus.wr_desc_valid = r_wr_valid;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.error         = (r_state == S_ERROR);
  assign bus.done_count    = r_done_count;

endmodule

// File: tb/tb_dma_dispatcher.sv
// Directed bench for dma_dispatcher (DEPTH=16, CNT_W=4).
module tb_dma_dispatcher;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CNT_W-1:0] exp_done;

  dma_dispatcher_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  dma_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dma_pkg::t_dma_descriptor mk(input int i);
    dma_pkg::t_dma_descriptor d;
    d.src_addr = 32'h1000_0000 + 32'(i);
    d.dst_addr = 32'h2000_0000 + 32'(i);
    d.length   = 16'(i + 1);
    return d;
  endfunction

  task automatic push(input dma_pkg::t_dma_descriptor d);
    bus.desc_in    = d;
    bus.desc_wr_en = 1'b1;
    tick();
    bus.desc_wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!(bus.rd_desc_valid && bus.wr_desc_valid) && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b11);
  endtask

  task automatic both_done();
    bus.rd_fsm_done = 1'b1;
    bus.wr_fsm_done = 1'b1;
    tick();
    bus.rd_fsm_done = 1'b0;
    bus.wr_fsm_done = 1'b0;
  endtask

  initial begin
    reset                   = 1'b1;
    bus.desc_in             = '0;
    bus.desc_wr_en          = 1'b0;
    bus.rd_fsm_done         = 1'b0;
    bus.wr_fsm_done         = 1'b0;
    bus.rd_stopped_on_error = 1'b0;
    bus.wr_stopped_on_error = 1'b0;
    bus.reset_dispatcher    = 1'b0;
    exp_done                = '0;
    tick();
    tick();
    check_eq("rst_valids",   {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
    check_eq("rst_status",   {bus.busy, bus.error, bus.desc_overflow, bus.desc_full}, 4'b0000);
    check_eq("rst_count",    bus.desc_count, 0);
    check_eq("rst_done",     bus.done_count, 0);
    check_eq("rst_desc",     bus.descriptor, 0);
    reset = 1'b0;
    tick();

    // Single descriptor: push at cycle 0, wr done at 10, rd done at 14.
    push(mk(0));                                          // now cycle 1
    check_eq("s_count1", bus.desc_count, 1);
    check_eq("s_idle1",  bus.busy, 0);
    tick();                                               // cycle 2 (LOAD)
    check_eq("s_load_busy", bus.busy, 1);
    check_eq("s_load_vld",  {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
    tick();                                               // cycle 3
    check_eq("s_vld3",   {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b11);
    check_eq("s_desc3",  bus.descriptor, mk(0));
    check_eq("s_count3", bus.desc_count, 0);
    for (int c = 3; c < 10; c++) tick();                  // cycle 10
    bus.wr_fsm_done = 1'b1;
    tick();                                               // cycle 11
    bus.wr_fsm_done = 1'b0;
    check_eq("s_vld11", {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b10);
    check_eq("s_done11", bus.done_count, 0);
    bus.wr_fsm_done = 1'b1;                               // repeat done on cleared side
    tick();
    bus.wr_fsm_done = 1'b0;
    tick();
    tick();                                               // cycle 14
    check_eq("s_vld14", {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b10);
    bus.rd_fsm_done = 1'b1;
    tick();                                               // cycle 15
    bus.rd_fsm_done = 1'b0;
    exp_done = exp_done + 1'b1;
    check_eq("s_vld15",  {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
    check_eq("s_done15", bus.done_count, exp_done);
    check_eq("s_idle15", bus.busy, 0);
    check_eq("s_desc15", bus.descriptor, mk(0));

    // Back-to-back D0..D3 with simultaneous dones.
    for (int i = 0; i < 4; i++) push(mk(10 + i));
    wait_valid("b_first_vld");
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("b_desc%0d", k), bus.descriptor, mk(10 + k));
      both_done();                                        // M+1
      exp_done = exp_done + 1'b1;
      check_eq($sformatf("b_vldoff%0d", k), {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
      check_eq($sformatf("b_done%0d", k), bus.done_count, exp_done);
      if (k < 3) begin
        tick();                                           // M+2
        check_eq($sformatf("b_vldon%0d", k), {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b11);
      end
    end
    check_eq("b_count_end", bus.desc_count, 0);
    tick();
    check_eq("b_idle_end", bus.busy, 0);

    // Overflow: one active descriptor, then 18 pushes into a 16-deep FIFO.
    push(mk(100));
    wait_valid("o_active_vld");
    for (int i = 0; i < 18; i++) begin
      push(mk(200 + i));
      if (i == 14) check_eq("o_notfull15", bus.desc_full, 0);
      if (i == 15) begin
        check_eq("o_full16",  bus.desc_full, 1);
        check_eq("o_ovf16",   bus.desc_overflow, 0);
      end
    end
    check_eq("o_count", bus.desc_count, 16);
    check_eq("o_ovf",   bus.desc_overflow, 1);
    both_done();                                          // M+1: LOAD, count still 16
    exp_done = exp_done + 1'b1;
    check_eq("o_full_load", bus.desc_full, 1);
    push(mk(999));                                        // dropped despite the pop
    check_eq("o_count_pop", bus.desc_count, 15);
    check_eq("o_vld_next",  {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b11);
    check_eq("o_desc_next", bus.descriptor, mk(200));
    check_eq("o_done",      bus.done_count, exp_done);

    // Error with a same-cycle rd done: error wins, no retire.
    bus.rd_fsm_done         = 1'b1;
    bus.wr_stopped_on_error = 1'b1;
    tick();
    bus.rd_fsm_done         = 1'b0;
    bus.wr_stopped_on_error = 1'b0;
    check_eq("e_error", bus.error, 1);
    check_eq("e_vld",   {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
    check_eq("e_done",  bus.done_count, exp_done);
    push(mk(300));
    tick();
    check_eq("e_hold",  bus.error, 1);
    check_eq("e_push",  bus.desc_count, 16);
    bus.reset_dispatcher = 1'b1;
    tick();
    bus.reset_dispatcher = 1'b0;
    check_eq("e_rd_state", {bus.busy, bus.error}, 2'b00);
    check_eq("e_rd_count", bus.desc_count, 0);
    check_eq("e_rd_ovf",   bus.desc_overflow, 0);
    check_eq("e_rd_done",  bus.done_count, exp_done);

    // Mid-operation abort with three queued and a same-cycle push.
    for (int i = 0; i < 4; i++) push(mk(400 + i));
    check_eq("a_run_vld", {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b11);
    check_eq("a_queued",  bus.desc_count, 3);
    bus.reset_dispatcher = 1'b1;
    bus.desc_in          = mk(404);
    bus.desc_wr_en       = 1'b1;
    tick();
    bus.reset_dispatcher = 1'b0;
    bus.desc_wr_en       = 1'b0;
    check_eq("a_idle",  bus.busy, 0);
    check_eq("a_count", bus.desc_count, 0);
    check_eq("a_vld",   {bus.rd_desc_valid, bus.wr_desc_valid}, 2'b00);
    for (int c = 0; c < 4; c++) tick();
    check_eq("a_noload", {bus.busy, bus.rd_desc_valid}, 2'b00);
    check_eq("a_done",   bus.done_count, exp_done);

    // Counter wrap from a fresh reset: 17 retires on a 4-bit counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_done = '0;
    check_eq("w_reset_done", bus.done_count, 0);
    for (int i = 0; i < 17; i++) begin
      push(mk(500 + i));
      wait_valid($sformatf("w_vld%0d", i));
      both_done();
      exp_done = exp_done + 1'b1;
      if (i >= 14) check_eq($sformatf("w_done%0d", i + 1), bus.done_count, exp_done);
    end
    check_eq("w_final", bus.done_count, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
